// File: rtl/mio_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: state encoding,
// read-word field positions and write command bit positions.
package mio_timer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

    localparam int EXPIRED_BIT  = 31;
    localparam int RUNNING_BIT  = 30;
    localparam int COUNT_W      = 30;

    localparam int CMD_BIT      = 31;
    localparam int PERIODIC_BIT = 30;
    localparam int CLEAR_BIT    = 0;

    // Builds the CPU-visible status word from the flag and count registers.
    function automatic logic [31:0] pack_read(
        input logic               expired,
        input logic               running,
        input logic [COUNT_W-1:0] remaining
    );
        logic [31:0] word;
        word                = 32'd0;
        word[EXPIRED_BIT]   = expired;
        word[RUNNING_BIT]   = running;
        word[COUNT_W-1:0]   = remaining;
        return word;
    endfunction

endpackage

// File: rtl/mio_timer_if.sv
// Bus-side signals of the timer peripheral: write strobe/data in, read word
// and expiry pulse out.
interface mio_timer_if;
    logic        timer_we;
    logic [31:0] timer_out;
    logic [31:0] timer_in;
    logic        expire_pulse;

    modport master (
        output timer_we,
        output timer_out,
        input  timer_in,
        input  expire_pulse
    );

    modport slave (
        input  timer_we,
        input  timer_out,
        output timer_in,
        output expire_pulse
    );
endinterface

// File: rtl/mio_timer_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_DIV enabled
// clocks; clear has priority and forces the count back to zero.
module timer_prescaler #(
    parameter int TICK_DIV = 100000,
    parameter int PRE_W    = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] count;

    assign tick = enable && !clear && (count == LAST);

    // Prescaler count: clear, wrap at LAST, or advance while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {PRE_W{1'b0}};
        end else if (clear) begin
            count <= {PRE_W{1'b0}};
        end else if (enable) begin
            if (count == LAST) begin
                count <= {PRE_W{1'b0}};
            end else begin
                count <= count + PRE_W'(1);
            end
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/mio_timer.sv
// Countdown timer peripheral: 30-bit counter decremented once per prescaler
// tick, one-shot or periodic, with a sticky expired flag and expiry pulse.
module mio_timer #(
    parameter int TICK_DIV = 100000,
    parameter int PRE_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    mio_timer_if.slave  bus
);
    import mio_timer_pkg::*;

    timer_state_t        state;
    logic [COUNT_W-1:0]  remaining;
    logic [COUNT_W-1:0]  reload;
    logic                periodic;
    logic                expired;
    logic                pulse;

    logic                is_load;
    logic                is_stop;
    logic                running;
    logic                pre_clear;
    logic                tick;

    assign is_load   = bus.timer_we && !bus.timer_out[CMD_BIT];
    assign is_stop   = bus.timer_we && bus.timer_out[CMD_BIT] && bus.timer_out[CLEAR_BIT];
    assign running   = (state == ST_RUN);
    // Holding the prescaler cleared outside RUN keeps every period aligned to its start edge.
    assign pre_clear = is_load || is_stop || !running;

    timer_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (pre_clear),
        .enable (running),
        .tick   (tick)
    );

    assign bus.timer_in     = pack_read(expired, running, remaining);
    assign bus.expire_pulse = pulse;

    // Control FSM: bus writes override any tick or expiry in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= {COUNT_W{1'b0}};
            reload    <= {COUNT_W{1'b0}};
            periodic  <= 1'b0;
            expired   <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (is_load) begin
                remaining <= bus.timer_out[COUNT_W-1:0];
                reload    <= bus.timer_out[COUNT_W-1:0];
                periodic  <= bus.timer_out[PERIODIC_BIT];
                expired   <= 1'b0;
                state     <= ST_RUN;
            end else if (is_stop) begin
                expired <= 1'b0;
                state   <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_RUN: begin
                        if (remaining == 30'd0) begin
                            // A zero load expires once and never re-arms.
                            expired <= 1'b1;
                            pulse   <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (tick) begin
                            if (remaining == 30'd1) begin
                                expired <= 1'b1;
                                pulse   <= 1'b1;
                                if (periodic) begin
                                    remaining <= reload;
                                end else begin
                                    remaining <= 30'd0;
                                    state     <= ST_IDLE;
                                end
                            end else begin
                                remaining <= remaining - 30'd1;
                            end
                        end else begin
                            remaining <= remaining;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
